// File: rtl/io_defs.sv
// Shared definitions for the I/O responder: register offsets,
// EVENT word layout and LFSR constants.
package io_defs;

  localparam logic [2:0] OFF_STATUS = 3'd0;
  localparam logic [2:0] OFF_EVENT  = 3'd1;
  localparam logic [2:0] OFF_RANDOM = 3'd2;
  localparam logic [2:0] OFF_P1     = 3'd3;
  localparam logic [2:0] OFF_P2     = 3'd4;
  localparam logic [2:0] OFF_P3     = 3'd5;
  localparam logic [2:0] OFF_P4     = 3'd6;
  localparam logic [2:0] OFF_CTRL   = 3'd7;

  localparam int EV_VALID_BIT = 15;
  localparam int EV_PLAYER_LO = 10;
  localparam int EV_SW_W      = 10;
  localparam int EV_DATA_W    = 14;

  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] DEF_SEED  = 16'hACE1;

  function automatic logic [15:0] ev_word(
    input logic [EV_DATA_W-1:0] d
  );
    return {1'b1, 1'b0, d};
  endfunction

  function automatic logic [15:0] lfsr_step(
    input logic [15:0] s
  );
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

endpackage

// File: rtl/io_responder_if.sv
// CPU-side bus of the I/O window: address, strobes, write data,
// registered read data with valid pulse, combinational hit.
interface io_responder_if;
  logic [15:0] adr;
  logic        memread;
  logic        memwrite;
  logic [15:0] writedata;
  logic [15:0] rdata;
  logic        rvalid;
  logic        hit;

  modport master (
    output adr, memread, memwrite, writedata,
    input  rdata, rvalid, hit
  );

  modport slave (
    input  adr, memread, memwrite, writedata,
    output rdata, rvalid, hit
  );
endinterface

// File: rtl/io_event_fifo.sv
// Synchronous event FIFO: push/pop/flush, din/dout, count,
// empty/full flags and an overflow_set pulse on a dropped push.
module io_event_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 14,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          overflow_set
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign count = cnt_q;
  assign dout  = mem_q[rp_q];

  always_comb begin
    mem_d        = mem_q;
    wp_d         = wp_q;
    rp_d         = rp_q;
    cnt_d        = cnt_q;
    do_pop       = pop && !empty;
    // a pop frees a slot for a push landing on the same edge
    do_push      = push && (!full || do_pop);
    overflow_set = push && full && !do_pop;
    if (flush) begin
      do_push      = 1'b0;
      do_pop       = 1'b0;
      overflow_set = 1'b0;
      wp_d         = '0;
      rp_d         = '0;
      cnt_d        = '0;
    end else begin
      if (do_push) begin
        mem_d[wp_q] = din;
        wp_d        = wp_q + 1'b1;
      end
      if (do_pop) rp_d = rp_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/io_responder.sv
// Memory-mapped I/O slave: status/event FIFO, LFSR, P1..P4 scores.
// Ports: clk, rst, bus (slave), controller inputs, scores, random.
module io_responder
  import io_defs::*;
#(
  parameter logic [15:0] IO_BASE    = 16'd43,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] LFSR_SEED  = DEF_SEED
) (
  input  logic           clk,
  input  logic           rst,
  io_responder_if.slave  bus,
  input  logic [3:0]     playerInput,
  input  logic           playerInputFlag,
  input  logic [9:0]     switchInput,
  output logic [15:0]    p1,
  output logic [15:0]    p2,
  output logic [15:0]    p3,
  output logic [15:0]    p4,
  output logic [15:0]    randomVal,
  output logic           eventPending
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic [15:0] p_q [4];
  logic [15:0] p_d [4];
  logic [15:0] lfsr_q, lfsr_d;
  logic        en_q, en_d;
  logic        ovf_q, ovf_d;
  logic        flag_q, flag_d;

  logic          hit, rd_en, wr_en, ctrl_wr;
  logic [2:0]    off;
  logic          push, pop, flush;
  logic [EV_DATA_W-1:0] f_dout;
  logic [CW-1:0] f_cnt;
  logic          f_empty, f_full, f_ovf;
  logic [15:0]   wd;

  assign wd = bus.writedata;

  always_comb begin
    hit = (bus.adr >= IO_BASE)
       && (bus.adr <= IO_BASE + 16'd7);
    // low bits suffice: the window is 8 words long
    off = bus.adr[2:0] - IO_BASE[2:0];
  end

  assign rd_en   = bus.memread && !bus.memwrite && hit;
  assign wr_en   = bus.memwrite && hit;
  assign ctrl_wr = wr_en && (off == OFF_CTRL);
  assign flush   = ctrl_wr && wd[1];
  assign pop     = rd_en && (off == OFF_EVENT);
  assign push    = playerInputFlag && !flag_q;

  io_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EV_DATA_W)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .pop          (pop),
    .flush        (flush),
    .din          ({playerInput, switchInput}),
    .dout         (f_dout),
    .count        (f_cnt),
    .empty        (f_empty),
    .full         (f_full),
    .overflow_set (f_ovf)
  );

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = rd_en;
    p_d      = p_q;
    lfsr_d   = lfsr_q;
    en_d     = en_q;
    ovf_d    = ovf_q;
    flag_d   = playerInputFlag;

    if (rd_en) begin
      unique case (off)
        OFF_STATUS: rdata_d = {11'd0, 3'(f_cnt),
                               ovf_q, !f_empty};
        OFF_EVENT:  rdata_d = f_empty ? 16'h0000
                                      : ev_word(f_dout);
        OFF_RANDOM: rdata_d = lfsr_q;
        OFF_P1:     rdata_d = p_q[0];
        OFF_P2:     rdata_d = p_q[1];
        OFF_P3:     rdata_d = p_q[2];
        OFF_P4:     rdata_d = p_q[3];
        OFF_CTRL:   rdata_d = 16'h0000;
        default:    rdata_d = 16'h0000;
      endcase
    end

    if (wr_en) begin
      unique case (off)
        OFF_P1:  p_d[0] = wd;
        OFF_P2:  p_d[1] = wd;
        OFF_P3:  p_d[2] = wd;
        OFF_P4:  p_d[3] = wd;
        default: ;
      endcase
    end

    if (ctrl_wr) begin
      en_d = wd[2];
      if (wd[0]) ovf_d = 1'b0;
    end
    // a dropped push on the clearing edge keeps the flag set
    if (f_ovf) ovf_d = 1'b1;

    if (en_q) lfsr_d = lfsr_step(lfsr_q);
    if (wr_en && (off == OFF_RANDOM))
      lfsr_d = (wd == 16'h0000) ? LFSR_SEED : wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      for (int i = 0; i < 4; i++) p_q[i] <= '0;
      lfsr_q   <= LFSR_SEED;
      en_q     <= 1'b1;
      ovf_q    <= 1'b0;
      flag_q   <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      p_q      <= p_d;
      lfsr_q   <= lfsr_d;
      en_q     <= en_d;
      ovf_q    <= ovf_d;
      flag_q   <= flag_d;
    end
  end

  assign bus.rdata   = rdata_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.hit     = hit;
  assign p1          = p_q[0];
  assign p2          = p_q[1];
  assign p3          = p_q[2];
  assign p4          = p_q[3];
  assign randomVal   = lfsr_q;
  assign eventPending = !f_empty;

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder with a read-data scoreboard.
// Expected reads are queued at the strobe and popped at rvalid.
module tb_io_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  playerInput = '0;
  logic        playerInputFlag = 1'b0;
  logic [9:0]  switchInput = '0;
  logic [15:0] p1, p2, p3, p4, randomVal;
  logic        eventPending;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q [$];

  io_responder_if bus ();

  io_responder dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .playerInput     (playerInput),
    .playerInputFlag (playerInputFlag),
    .switchInput     (switchInput),
    .p1              (p1),
    .p2              (p2),
    .p3              (p3),
    .p4              (p4),
    .randomVal       (randomVal),
    .eventPending    (eventPending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a,
                    input logic [15:0] d);
    bus.adr = a;
    bus.writedata = d;
    bus.memwrite = 1'b1;
    cyc();
    bus.memwrite = 1'b0;
  endtask

  // scoreboard: expected word queued with the strobe
  task automatic rd_compare(input string tag);
    logic [15:0] e;
    chk({tag, "_rvalid"}, 16'(bus.rvalid), 16'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 16'd1, 16'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, bus.rdata, e);
    end
  endtask

  task automatic rd(input string tag,
                    input logic [15:0] a,
                    input logic [15:0] e);
    bus.adr = a;
    bus.memread = 1'b1;
    exp_q.push_back(e);
    cyc();
    bus.memread = 1'b0;
    rd_compare(tag);
  endtask

  task automatic buzz(input logic [3:0] pl,
                      input logic [9:0] sw,
                      input int hold);
    playerInput = pl;
    switchInput = sw;
    playerInputFlag = 1'b1;
    repeat (hold) cyc();
    playerInputFlag = 1'b0;
    cyc();
  endtask

  initial begin
    bus.adr = '0;
    bus.memread = 1'b0;
    bus.memwrite = 1'b0;
    bus.writedata = '0;

    // reset values
    #12;
    chk("rst_rvalid", 16'(bus.rvalid), 16'd0);
    chk("rst_rdata", bus.rdata, 16'h0000);
    chk("rst_p1", p1, 16'h0000);
    chk("rst_rand", randomVal, 16'hACE1);
    chk("rst_pend", 16'(eventPending), 16'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc();

    rd("status0", 16'd43, 16'h0000);
    cyc();
    chk("rvalid_drop", 16'(bus.rvalid), 16'd0);

    // stop LFSR, reload default seed
    wr(16'd50, 16'h0000);
    wr(16'd45, 16'h0000);
    rd("rand_seed", 16'd45, 16'hACE1);

    // score registers and window edges
    wr(16'd46, 16'h0123);
    chk("p1_wr", p1, 16'h0123);
    wr(16'd49, 16'h00FF);
    chk("p4_wr", p4, 16'h00FF);
    rd("p1_rd", 16'd46, 16'h0123);
    rd("p4_rd", 16'd49, 16'h00FF);
    bus.adr = 16'd42;
    #1 chk("hit_42", 16'(bus.hit), 16'd0);
    bus.adr = 16'd50;
    #1 chk("hit_50", 16'(bus.hit), 16'd1);
    bus.adr = 16'd51;
    #1 chk("hit_51", 16'(bus.hit), 16'd0);
    wr(16'd42, 16'hFFFF);
    wr(16'd51, 16'hFFFF);
    chk("miss_p1", p1, 16'h0123);
    chk("miss_p2", p2, 16'h0000);
    chk("miss_p3", p3, 16'h0000);
    chk("miss_p4", p4, 16'h00FF);
    rd("ctrl_rd", 16'd50, 16'h0000);

    // held flag yields a single event
    buzz(4'b0100, 10'h2A5, 5);
    rd("st_one", 16'd43, 16'h0005);
    rd("ev_one", 16'd44, 16'h92A5);
    rd("st_emp", 16'd43, 16'h0000);
    rd("ev_emp", 16'd44, 16'h0000);

    // fill and overflow
    buzz(4'b0001, 10'h001, 1);
    buzz(4'b0010, 10'h002, 1);
    buzz(4'b0100, 10'h003, 1);
    buzz(4'b1000, 10'h004, 1);
    buzz(4'b0001, 10'h005, 1);
    rd("st_ovf", 16'd43, 16'h0013);
    rd("ev_first", 16'd44, 16'h8401);
    rd("st_three", 16'd43, 16'h000F);
    buzz(4'b0010, 10'h006, 1);
    wr(16'd50, 16'h0001);
    rd("st_clr", 16'd43, 16'h0011);

    // pop and push together while full
    playerInput = 4'b0010;
    switchInput = 10'h3FF;
    playerInputFlag = 1'b1;
    rd("ev_popush", 16'd44, 16'h8802);
    playerInputFlag = 1'b0;
    cyc();
    rd("st_popush", 16'd43, 16'h0011);

    // LFSR seed handling
    wr(16'd45, 16'h0000);
    rd("rand_zero", 16'd45, 16'hACE1);
    wr(16'd50, 16'h0004);
    wr(16'd45, 16'h0001);
    chk("lfsr_seed1", randomVal, 16'h0001);
    cyc();
    chk("lfsr_step1", randomVal, 16'hB400);
    cyc();
    chk("lfsr_step2", randomVal, 16'h5A00);

    // flush beats a push on the same edge
    playerInput = 4'b1000;
    switchInput = 10'h111;
    playerInputFlag = 1'b1;
    wr(16'd50, 16'h0006);
    playerInputFlag = 1'b0;
    cyc();
    rd("st_flush", 16'd43, 16'h0000);

    // read+write together is a write only
    buzz(4'b0001, 10'h00A, 1);
    buzz(4'b0010, 10'h00B, 1);
    rd("st_two", 16'd43, 16'h0009);
    bus.adr = 16'd44;
    bus.writedata = 16'h0000;
    bus.memread = 1'b1;
    bus.memwrite = 1'b1;
    cyc();
    bus.memread = 1'b0;
    bus.memwrite = 1'b0;
    chk("rw_novalid", 16'(bus.rvalid), 16'd0);
    rd("st_rw", 16'd43, 16'h0009);

    // reset during a pending read
    wr(16'd46, 16'h5555);
    bus.adr = 16'd43;
    bus.memread = 1'b1;
    cyc();
    #3 rst = 1'b1;
    #1;
    chk("mrst_rvalid", 16'(bus.rvalid), 16'd0);
    chk("mrst_rdata", bus.rdata, 16'h0000);
    chk("mrst_p1", p1, 16'h0000);
    chk("mrst_pend", 16'(eventPending), 16'd0);
    chk("mrst_rand", randomVal, 16'hACE1);
    bus.memread = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("post_rvalid", 16'(bus.rvalid), 16'd0);
    rd("post_status", 16'd43, 16'h0000);

    chk("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
